rmssd_window_ctrl: RTL and testbench
====================================

Name: rmssd_window_ctrl

Overview:
- Sequencer for the RMSSD (heart-rate-variability) engine.
- Assembles 16-bit RR intervals in ms from a byte stream and forms absolute successive differences.
- Schedules a shared external arithmetic unit (ALU) through a start/done handshake: a SQUARE op per difference, then one SQRT op per window. Accumulates squares and publishes one RMSSD result per window of 2^LOG2_N differences.

Parameters:
- LOG2_N, 3, log2 of differences per window (window = 8).
- W, 16, RR interval width in bits.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  synchronous active-low reset.
- ena  input  1  design enable. When low, all state holds and inputs are ignored.
- clear  input  1  synchronous soft clear of the window.
- byte_in  input  8  RR byte, low byte first.
- byte_valid  input  1  one-cycle strobe qualifying byte_in.
- alu_start  output  1  one-cycle op launch pulse.
- alu_op  output  1  0 = SQUARE, 1 = SQRT.
- alu_a  output  32  ALU operand.
- alu_done  input  1  one-cycle completion pulse.
- alu_result  input  32  ALU result, valid with alu_done.
- rmssd_out  output  16  last RMSSD in ms.
- rmssd_valid  output  1  one-cycle pulse when rmssd_out updates.
- busy  output  1  high in every state except IDLE.
- overrun  output  1  sticky: a byte arrived while busy.

Behaviour:
- Reset (rst_n low at a clk edge):
  - All outputs 0, FSM in IDLE.
  - acc = 0, count = 0, prev_valid = 0, byte phase = low.
- FSM states and transitions:
  - IDLE: accepts byte_valid.
    - Phase low: latch byte_in as rr[7:0].
    - Phase high: form rr = {byte_in, rr_lo}.
    - If prev_valid = 0: prev <= rr, prev_valid <= 1, stay in IDLE.
    - Otherwise: diff = |rr - prev| (unsigned W bits), prev <= rr. Next cycle, assert alu_start with op SQUARE and alu_a = {16'b0, diff}, then go to WAIT_SQ.
  - WAIT_SQ: on alu_done, acc <= acc + alu_result, count <= count + 1.
    - If count + 1 == 2^LOG2_N: go to ISSUE_SQRT.
    - Otherwise: go to IDLE.
  - ISSUE_SQRT: alu_start with op SQRT and alu_a = acc >> LOG2_N (low 32 bits), then go to WAIT_SQRT.
  - WAIT_SQRT: on alu_done, rmssd_out <= alu_result[15:0], pulse rmssd_valid for exactly 1 cycle, acc <= 0, count <= 0, go to IDLE.
    - prev is kept, so consecutive windows share their boundary sample.
- Accumulator: width 32 + LOG2_N bits, so it cannot wrap. count is LOG2_N + 1 bits.
- ALU handshake:
  - alu_op and alu_a stay stable from the alu_start cycle until alu_done is seen.
  - alu_done may arrive no earlier than the cycle after alu_start.
  - alu_done in any state other than WAIT_SQ or WAIT_SQRT is ignored.
- Timing:
  - Earliest latency from the high byte to alu_start is 1 cycle.
  - Earliest latency from the SQRT alu_done to rmssd_valid is 1 cycle (registered).
- Busy/overrun:
  - byte_valid outside IDLE drops the byte and sets overrun.
  - overrun clears only on clear or reset.
  - Byte phase does not advance on a dropped byte.
- clear (when ena = 1):
  - Next state is IDLE; acc, count, prev_valid, byte phase and overrun are cleared.
  - rmssd_out is retained.
  - Clear has priority over byte_valid and alu_done in the same cycle.
  - Clear mid-WAIT_SQ/WAIT_SQRT abandons the op, and a later stale alu_done is ignored.
- ena low: no state or output changes; rmssd_valid and alu_start are forced 0. A byte_valid during ena low is lost without setting overrun.
- Reset mid-operation: same as the reset values above. The ALU owner is responsible for discarding its own in-flight op.

Test Plan:
- Basic window: LOG2_N = 2, ALU model with 3-cycle latency. RR 800, 810, 800, 810, 800 (bytes 0x20,0x03, 0x2A,0x03, …) -> four SQUARE ops each with a = 10, acc = 400, SQRT a = 100. rmssd_out = 10 with a single rmssd_valid pulse.
- Direction/abs: RR 1000, 950, 1000 -> SQUARE operands 50 and 50; no negative or wrap values appear on alu_a.
- Back-to-back windows: 9 RR values with LOG2_N = 2 -> 2 results. The second window's first diff uses RR #5 as prev. count and acc return to 0 after each window.
- Overrun: send a byte during WAIT_SQ -> overrun = 1, byte dropped, next RR assembled correctly from the following two bytes. clear -> overrun = 0.
- Clear mid-SQRT: assert clear in WAIT_SQRT, then deliver alu_done -> no rmssd_valid, rmssd_out unchanged, busy = 0. A new window then starts from an empty prev.
- ena/reset: drop ena during WAIT_SQ while alu_done pulses -> the done is ignored and the FSM holds (the bench re-issues done after ena returns). Assert rst_n = 0 mid-window -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/rmssd_window_ctrl.sv
// rmssd_window_ctrl: assembles RR intervals from a byte stream, forms absolute
// successive differences and sequences a shared ALU (SQUARE per difference,
// SQRT per window) to publish one RMSSD value per window of 2^LOG2_N diffs.
module rmssd_window_ctrl #(
    parameter int LOG2_N = 3,
    parameter int W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic        clear,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        alu_start,
    output logic        alu_op,
    output logic [31:0] alu_a,
    input  logic        alu_done,
    input  logic [31:0] alu_result,
    output logic [15:0] rmssd_out,
    output logic        rmssd_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int ACC_W = 32 + LOG2_N;
    localparam int CNT_W = LOG2_N + 1;
    localparam logic [CNT_W-1:0] WIN_LEN = CNT_W'(1 << LOG2_N);

    localparam logic OP_SQUARE = 1'b0;
    localparam logic OP_SQRT   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_SQ,
        S_WAIT_SQ,
        S_ISSUE_SQRT,
        S_WAIT_SQRT
    } state_t;

    state_t state, state_nxt;

    // Byte assembly and window bookkeeping
    logic             phase;       // 0: expecting low byte, 1: expecting high byte
    logic [7:0]       rr_lo;
    logic [W-1:0]     prev;
    logic             prev_valid;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             rmssd_vld_p1;

    // Decoded per-cycle events from the FSM
    logic             take_lo;
    logic             take_hi;
    logic             drop;
    logic             sq_done;
    logic             sqrt_done;
    logic             last_sq;

    logic [W-1:0]     rr_word;
    logic [CNT_W-1:0] count_inc;
    logic [ACC_W-1:0] acc_sum;

    // |a - b| computed in a signed domain one bit wider, so it never wraps
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [W:0] d;
        logic signed [W:0] nd;
        d  = $signed({1'b0, a}) - $signed({1'b0, b});
        nd = -d;
        return d[W] ? nd[W-1:0] : d[W-1:0];
    endfunction

    // Mean of the window's squares: truncating divide by 2^LOG2_N; the mean of
    // W-bit squares always fits in 32 bits, so the slice loses nothing
    function automatic logic [31:0] window_mean(input logic [ACC_W-1:0] sum);
        return sum[LOG2_N +: 32];
    endfunction

    assign rr_word   = W'({byte_in, rr_lo});
    assign count_inc = count + CNT_W'(1);
    assign acc_sum   = acc + ACC_W'(alu_result);
    assign last_sq   = (count_inc == WIN_LEN);

    assign rmssd_valid = rmssd_vld_p1 & ena;

    // FSM state register; everything freezes while ena is low
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else if (ena) begin
            state <= state_nxt;
        end
    end

    // Next-state decode, event strobes and handshake outputs
    always_comb begin
        state_nxt = state;
        take_lo   = 1'b0;
        take_hi   = 1'b0;
        drop      = 1'b0;
        sq_done   = 1'b0;
        sqrt_done = 1'b0;
        busy      = (state != S_IDLE);
        alu_start = ena && !clear && ((state == S_ISSUE_SQ) || (state == S_ISSUE_SQRT));
        if (clear) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (byte_valid) begin
                        if (!phase) begin
                            take_lo = 1'b1;
                        end else begin
                            take_hi = 1'b1;
                            if (prev_valid) state_nxt = S_ISSUE_SQ;
                        end
                    end
                end
                S_ISSUE_SQ: begin
                    drop      = byte_valid;
                    state_nxt = S_WAIT_SQ;
                end
                S_WAIT_SQ: begin
                    drop = byte_valid;
                    if (alu_done) begin
                        sq_done   = 1'b1;
                        state_nxt = last_sq ? S_ISSUE_SQRT : S_IDLE;
                    end
                end
                S_ISSUE_SQRT: begin
                    drop      = byte_valid;
                    state_nxt = S_WAIT_SQRT;
                end
                S_WAIT_SQRT: begin
                    drop = byte_valid;
                    if (alu_done) begin
                        sqrt_done = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Control, accumulator and output registers; clear keeps the last result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase        <= 1'b0;
            prev_valid   <= 1'b0;
            acc          <= '0;
            count        <= '0;
            overrun      <= 1'b0;
            rmssd_out    <= '0;
            rmssd_vld_p1 <= 1'b0;
            alu_op       <= OP_SQUARE;
            alu_a        <= '0;
        end else if (ena) begin
            rmssd_vld_p1 <= 1'b0;
            if (clear) begin
                phase      <= 1'b0;
                prev_valid <= 1'b0;
                acc        <= '0;
                count      <= '0;
                overrun    <= 1'b0;
            end else begin
                if (drop) overrun <= 1'b1;
                if (take_lo) phase <= 1'b1;
                if (take_hi) begin
                    phase      <= 1'b0;
                    prev_valid <= 1'b1;
                    if (prev_valid) begin
                        alu_op <= OP_SQUARE;
                        alu_a  <= 32'(abs_diff(rr_word, prev));
                    end
                end
                if (sq_done) begin
                    acc   <= acc_sum;
                    count <= count_inc;
                    if (last_sq) begin
                        alu_op <= OP_SQRT;
                        alu_a  <= window_mean(acc_sum);
                    end
                end
                if (sqrt_done) begin
                    rmssd_out    <= alu_result[15:0];
                    rmssd_vld_p1 <= 1'b1;
                    acc          <= '0;
                    count        <= '0;
                end
            end
        end
    end

    // RR data registers; prev is only meaningful while prev_valid is set
    always_ff @(posedge clk) begin
        if (ena && take_lo) rr_lo <= byte_in;
        if (ena && take_hi) prev  <= rr_word;
    end

endmodule

// File: tb/tb_rmssd_window_ctrl.sv
// tb_rmssd_window_ctrl: table vectors, hand-written corner sequences and
// randomized RR streams against a behavioural RMSSD reference model.
`timescale 1ns/1ps
module tb_rmssd_window_ctrl;

    localparam int LOG2_N = 2;
    localparam int WIN    = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst_n, ena, clear, byte_valid;
    logic [7:0]  byte_in;
    logic        alu_start, alu_op, alu_done;
    logic [31:0] alu_a, alu_result;
    logic [15:0] rmssd_out;
    logic        rmssd_valid, busy, overrun;

    int checks   = 0;
    int failures = 0;

    // ALU model controls (written only by the main process)
    int alu_lat  = 3;
    bit alu_auto = 1'b1;
    int done_req = 0;
    // ALU model state (written only by the model process)
    int done_served;

    logic [32:0] op_log[$];   // {op, a} of every launched op
    logic [15:0] res_log[$];  // rmssd_out at every rmssd_valid
    logic [15:0] exp_out = 16'd0;

    logic [15:0] ref_rr[$];
    logic [32:0] ref_ops[$];
    logic [15:0] ref_res[$];

    typedef struct {
        int          n_rr;
        logic [15:0] rr [9];
        int          n_ops;
        logic [32:0] ops [10];
        int          n_res;
        logic [15:0] res [2];
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    rmssd_window_ctrl #(.LOG2_N(LOG2_N), .W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .clear      (clear),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_done   (alu_done),
        .alu_result (alu_result),
        .rmssd_out  (rmssd_out),
        .rmssd_valid(rmssd_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    function automatic longint isqrt(input longint x);
        longint r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    function automatic logic [31:0] alu_calc(input logic op, input logic [31:0] a);
        longint v = longint'(a);
        if (op) return 32'(isqrt(v));
        return 32'(v * v);
    endfunction

    function automatic logic [32:0] sq_op(input int a);
        return {1'b0, 32'(a)};
    endfunction

    function automatic logic [32:0] sqrt_op(input longint a);
        return {1'b1, 32'(a)};
    endfunction

    function automatic longint op_at(input int i);
        if (i < op_log.size()) return longint'(op_log[i]);
        return -1;
    endfunction

    function automatic int res_at(input int i);
        if (i < res_log.size()) return int'(res_log[i]);
        return -1;
    endfunction

    // Reference: successive |dRR| -> SQUARE ops; every WIN diffs a SQRT of the
    // truncated mean square and one result. Windows share boundary samples.
    function automatic void ref_model();
        longint sum = 0;
        int     cnt = 0;
        longint a, b, d, m;
        ref_ops.delete();
        ref_res.delete();
        for (int i = 1; i < ref_rr.size(); i++) begin
            a = longint'(ref_rr[i]);
            b = longint'(ref_rr[i-1]);
            d = (a >= b) ? a - b : b - a;
            ref_ops.push_back({1'b0, 32'(d)});
            sum += d * d;
            cnt++;
            if (cnt == WIN) begin
                m = sum / WIN;
                ref_ops.push_back({1'b1, 32'(m)});
                ref_res.push_back(16'(isqrt(m)));
                sum = 0;
                cnt = 0;
            end
        end
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_byte(input logic [7:0] b);
        byte_in    = b;
        byte_valid = 1'b1;
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (busy !== 1'b0) check({name, " idle timeout"}, longint'(busy), 0);
    endtask

    task automatic send_rr(input logic [15:0] rr, input int gap);
        wait_idle("send_rr");
        drive_byte(rr[7:0]);
        repeat (gap) tick();
        drive_byte(rr[15:8]);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // Ask the ALU model for one done pulse, a cycle clear of the launch
    task automatic manual_done();
        tick();
        done_req = done_req + 1;
        tick();
        tick();
    endtask

    // ALU model: logs launches, answers after alu_lat cycles or on request
    initial begin : alu_model
        logic        pop;
        logic [31:0] pa;
        int          wait_cnt;
        pop         = 1'b0;
        pa          = '0;
        wait_cnt    = -1;
        done_served = 0;
        alu_done    = 1'b0;
        alu_result  = '0;
        forever begin
            @(negedge clk);
            alu_done = 1'b0;
            if (rst_n !== 1'b1) begin
                wait_cnt = -1;
            end else begin
                if (wait_cnt > 0) begin
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        alu_done   = 1'b1;
                        alu_result = alu_calc(pop, pa);
                        wait_cnt   = -1;
                    end
                end
                if (done_req != done_served) begin
                    done_served = done_served + 1;
                    alu_done    = 1'b1;
                    alu_result  = alu_calc(pop, pa);
                end
                if (alu_start === 1'b1) begin
                    pop = alu_op;
                    pa  = alu_a;
                    op_log.push_back({alu_op, alu_a});
                    if (alu_auto) wait_cnt = alu_lat;
                end
            end
        end
    end

    // Result monitor
    initial begin : res_mon
        forever begin
            @(negedge clk);
            if (rmssd_valid === 1'b1) res_log.push_back(rmssd_out);
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        int ob, rb, n;
        logic [15:0] rr;

        vecs[0].n_rr  = 5;
        vecs[0].rr    = '{16'd800, 16'd810, 16'd800, 16'd810, 16'd800, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[0].n_ops = 5;
        vecs[0].ops   = '{sq_op(10), sq_op(10), sq_op(10), sq_op(10), sqrt_op(100),
                          '0, '0, '0, '0, '0};
        vecs[0].n_res = 1;
        vecs[0].res   = '{16'd10, 16'd0};

        vecs[1].n_rr  = 3;
        vecs[1].rr    = '{16'd1000, 16'd950, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[1].n_ops = 2;
        vecs[1].ops   = '{sq_op(50), sq_op(50), '0, '0, '0, '0, '0, '0, '0, '0};
        vecs[1].n_res = 0;
        vecs[1].res   = '{16'd0, 16'd0};

        vecs[2].n_rr  = 9;
        vecs[2].rr    = '{16'd800, 16'd810, 16'd800, 16'd810, 16'd800,
                          16'd830, 16'd800, 16'd830, 16'd800};
        vecs[2].n_ops = 10;
        vecs[2].ops   = '{sq_op(10), sq_op(10), sq_op(10), sq_op(10), sqrt_op(100),
                          sq_op(30), sq_op(30), sq_op(30), sq_op(30), sqrt_op(900)};
        vecs[2].n_res = 2;
        vecs[2].res   = '{16'd10, 16'd30};

        vecs[3].n_rr  = 5;
        vecs[3].rr    = '{16'd500, 16'd500, 16'd500, 16'd500, 16'd500, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[3].n_ops = 5;
        vecs[3].ops   = '{sq_op(0), sq_op(0), sq_op(0), sq_op(0), sqrt_op(0),
                          '0, '0, '0, '0, '0};
        vecs[3].n_res = 1;
        vecs[3].res   = '{16'd0, 16'd0};

        vecs[4].n_rr  = 5;
        vecs[4].rr    = '{16'd65535, 16'd0, 16'd65535, 16'd0, 16'd65535, 16'd0, 16'd0, 16'd0, 16'd0};
        vecs[4].n_ops = 5;
        vecs[4].ops   = '{sq_op(65535), sq_op(65535), sq_op(65535), sq_op(65535),
                          sqrt_op(64'hFFFE0001), '0, '0, '0, '0, '0};
        vecs[4].n_res = 1;
        vecs[4].res   = '{16'd65535, 16'd0};

        rst_n      = 1'b0;
        ena        = 1'b1;
        clear      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset alu_start", longint'(alu_start), 0);
        check("reset alu_op", longint'(alu_op), 0);
        check("reset alu_a", longint'(alu_a), 0);
        check("reset rmssd_out", longint'(rmssd_out), 0);
        check("reset rmssd_valid", longint'(rmssd_valid), 0);
        check("reset busy", longint'(busy), 0);
        check("reset overrun", longint'(overrun), 0);
        rst_n = 1'b1;
        tick();

        // Table-driven windows
        for (int v = 0; v < 5; v++) begin
            pulse_clear();
            ob = op_log.size();
            rb = res_log.size();
            for (int i = 0; i < vecs[v].n_rr; i++) send_rr(vecs[v].rr[i], 0);
            wait_idle("vec");
            repeat (3) tick();
            check($sformatf("vec%0d op count", v), op_log.size() - ob, vecs[v].n_ops);
            for (int i = 0; i < vecs[v].n_ops; i++)
                check($sformatf("vec%0d op%0d", v, i), op_at(ob + i), longint'(vecs[v].ops[i]));
            check($sformatf("vec%0d result count", v), res_log.size() - rb, vecs[v].n_res);
            for (int i = 0; i < vecs[v].n_res; i++)
                check($sformatf("vec%0d result%0d", v, i), res_at(rb + i), vecs[v].res[i]);
            if (vecs[v].n_res > 0) exp_out = vecs[v].res[vecs[v].n_res - 1];
            check($sformatf("vec%0d rmssd_out", v), longint'(rmssd_out), exp_out);
        end

        // Overrun: byte during a busy op is dropped without advancing the phase
        pulse_clear();
        ob = op_log.size();
        send_rr(16'd800, 0);
        send_rr(16'd810, 0);
        drive_byte(8'hAA);
        check("overrun set", longint'(overrun), 1);
        send_rr(16'd790, 0);
        wait_idle("overrun");
        tick();
        check("overrun op count", op_log.size() - ob, 2);
        check("overrun next diff", op_at(ob + 1), longint'(sq_op(20)));
        check("overrun sticky", longint'(overrun), 1);
        pulse_clear();
        check("overrun cleared", longint'(overrun), 0);

        // Clear while waiting for SQRT; the late done must be ignored
        alu_auto = 1'b0;
        pulse_clear();
        ob = op_log.size();
        rb = res_log.size();
        send_rr(16'd1000, 0);
        for (int k = 0; k < 4; k++) begin
            send_rr((k % 2 == 0) ? 16'd1004 : 16'd1000, 0);
            manual_done();
        end
        check("sqrt pending busy", longint'(busy), 1);
        check("sqrt pending op", op_at(ob + 4), longint'(sqrt_op(16)));
        pulse_clear();
        manual_done();
        repeat (2) tick();
        check("clear sqrt no result", res_log.size() - rb, 0);
        check("clear sqrt rmssd_out kept", longint'(rmssd_out), exp_out);
        check("clear sqrt idle", longint'(busy), 0);
        send_rr(16'd900, 0);
        tick();
        check("clear prev empty", op_log.size() - ob, 5);
        send_rr(16'd905, 0);
        tick();
        check("clear new diff", op_at(ob + 5), longint'(sq_op(5)));
        manual_done();

        // ena low freezes WAIT_SQ: done and bytes during ena low are lost
        pulse_clear();
        ob = op_log.size();
        rb = res_log.size();
        send_rr(16'd800, 0);
        send_rr(16'd810, 0);
        tick();
        tick();
        ena = 1'b0;
        manual_done();
        drive_byte(8'h55);
        repeat (2) tick();
        check("ena low holds busy", longint'(busy), 1);
        check("ena low no overrun", longint'(overrun), 0);
        check("ena low no start", longint'(alu_start), 0);
        ena = 1'b1;
        repeat (2) tick();
        check("ena done ignored", longint'(busy), 1);
        manual_done();
        check("ena done accepted", longint'(busy), 0);
        send_rr(16'd800, 0);
        manual_done();
        send_rr(16'd810, 0);
        manual_done();
        send_rr(16'd800, 0);
        manual_done();
        check("ena op count", op_log.size() - ob, 5);
        check("ena sqrt op", op_at(ob + 4), longint'(sqrt_op(100)));
        manual_done();
        repeat (2) tick();
        check("ena result count", res_log.size() - rb, 1);
        check("ena result", res_at(rb), 10);
        exp_out = 16'd10;
        alu_auto = 1'b1;

        // Reset mid-window
        pulse_clear();
        send_rr(16'd800, 0);
        send_rr(16'd810, 0);
        drive_byte(8'h11);
        rst_n = 1'b0;
        tick();
        check("midreset busy", longint'(busy), 0);
        check("midreset overrun", longint'(overrun), 0);
        check("midreset alu_start", longint'(alu_start), 0);
        check("midreset alu_a", longint'(alu_a), 0);
        check("midreset alu_op", longint'(alu_op), 0);
        check("midreset rmssd_out", longint'(rmssd_out), 0);
        check("midreset rmssd_valid", longint'(rmssd_valid), 0);
        rst_n   = 1'b1;
        exp_out = 16'd0;
        tick();
        ob = op_log.size();
        send_rr(16'd700, 0);
        send_rr(16'd707, 0);
        wait_idle("post reset");
        check("post reset op count", op_log.size() - ob, 1);
        check("post reset diff", op_at(ob), longint'(sq_op(7)));

        // Randomized RR streams against the reference model
        for (int r = 0; r < 4; r++) begin
            alu_lat = $urandom_range(1, 5);
            pulse_clear();
            ob = op_log.size();
            rb = res_log.size();
            ref_rr.delete();
            n = $urandom_range(6, 14);
            for (int i = 0; i < n; i++) begin
                if (r == 3 && (i % 3) == 0) rr = 16'($urandom_range(0, 65535));
                else                        rr = 16'($urandom_range(400, 1400));
                ref_rr.push_back(rr);
                send_rr(rr, $urandom_range(0, 2));
                repeat ($urandom_range(0, 2)) tick();
            end
            wait_idle("random");
            repeat (3) tick();
            ref_model();
            check($sformatf("rand%0d op count", r), op_log.size() - ob, ref_ops.size());
            for (int i = 0; i < ref_ops.size(); i++)
                check($sformatf("rand%0d op%0d", r, i), op_at(ob + i), longint'(ref_ops[i]));
            check($sformatf("rand%0d result count", r), res_log.size() - rb, ref_res.size());
            for (int i = 0; i < ref_res.size(); i++)
                check($sformatf("rand%0d result%0d", r, i), res_at(rb + i), ref_res[i]);
            if (ref_res.size() > 0) exp_out = ref_res[ref_res.size() - 1];
            check($sformatf("rand%0d rmssd_out", r), longint'(rmssd_out), exp_out);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
